// File: rtl/connect_n_pkg.sv
// Shared types for the Connect-N cabinet game: FSM states, board cell
// encoding, line-checker scan directions and small helpers.
package connect_n_pkg;

   typedef enum logic [2:0] {IDLE, PLAY, DROP, CHECK, GAME_OVER} state_t;
   typedef enum logic [1:0] {EMPTY = 2'b00, RED = 2'b01, YELLOW = 2'b10} cell_t;
   typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D1, DIR_D2} dir_t;

   function automatic dir_t next_dir(input dir_t d);
      unique case (d)
         DIR_H:   return DIR_V;
         DIR_V:   return DIR_D1;
         DIR_D1:  return DIR_D2;
         default: return DIR_H;
      endcase
   endfunction

   function automatic cell_t other_player(input cell_t p);
      return (p == RED) ? YELLOW : RED;
   endfunction

endpackage

// File: rtl/connect_n_line_checker.sv
// Incremental Connect-N line checker: walks outward from the last placed
// piece one cell per cycle, reading the board through rd_row/rd_col/rd_cell.
module connect_n_line_checker
   import connect_n_pkg::*;
#(
   parameter int ROWS    = 6,
   parameter int COLS    = 7,
   parameter int WIN_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] row,
   input  logic [2:0] col,
   input  cell_t      player,
   output logic [2:0] rd_row,
   output logic [2:0] rd_col,
   input  cell_t      rd_cell,
   output logic       done,
   output logic       win
);

   logic       busy;
   logic       minus;
   dir_t       dir;
   cell_t      me;
   logic [2:0] r0, c0, r, c;
   logic [3:0] count;
   logic       r_inc, r_dec, c_inc, c_dec, in_bounds, match;

   always_comb begin
      r_inc = 1'b0;
      r_dec = 1'b0;
      c_inc = 1'b0;
      c_dec = 1'b0;
      unique case (dir)
         DIR_H:   begin c_inc = !minus; c_dec = minus; end
         DIR_V:   begin r_inc = !minus; r_dec = minus; end
         DIR_D1:  begin r_inc = !minus; c_inc = !minus; r_dec = minus; c_dec = minus; end
         default: begin r_inc = !minus; c_dec = !minus; r_dec = minus; c_inc = minus; end
      endcase
      // Bounds are tested before stepping so coordinates never leave the board.
      in_bounds = !(r_inc && r == 3'(ROWS - 1)) && !(r_dec && r == 3'd0) &&
                  !(c_inc && c == 3'(COLS - 1)) && !(c_dec && c == 3'd0);
      rd_row = r + {2'b00, r_inc} - {2'b00, r_dec};
      rd_col = c + {2'b00, c_inc} - {2'b00, c_dec};
      match  = busy && in_bounds && (rd_cell == me) && (count < 4'(WIN_LEN));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         win   <= 1'b0;
         minus <= 1'b0;
         dir   <= DIR_H;
         me    <= EMPTY;
         r0    <= '0;
         c0    <= '0;
         r     <= '0;
         c     <= '0;
         count <= 4'd1;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy  <= 1'b1;
            win   <= 1'b0;
            minus <= 1'b0;
            dir   <= DIR_H;
            me    <= player;
            r0    <= row;
            c0    <= col;
            r     <= row;
            c     <= col;
            count <= 4'd1;
         end else if (busy) begin
            if (match) begin
               count <= count + 4'd1;
               r     <= rd_row;
               c     <= rd_col;
               if (count + 4'd1 == 4'(WIN_LEN)) begin
                  win  <= 1'b1;
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end else if (!minus) begin
               minus <= 1'b1;
               r     <= r0;
               c     <= c0;
            end else if (dir == DIR_D2) begin
               done <= 1'b1;
               busy <= 1'b0;
            end else begin
               dir   <= next_dir(dir);
               minus <= 1'b0;
               r     <= r0;
               c     <= c0;
               count <= 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/connect_n_game.sv
// Connect-N cabinet game top: cursor/drop/check FSM, board and display.
// Define CONNECT_N_UNDO_EN to enable the single-step undo on btn_pulse[0].
module connect_n_game
   import connect_n_pkg::*;
#(
   parameter int COLS       = 7,
   parameter int ROWS       = 6,
   parameter int WIN_LEN    = 4,
   parameter int DROP_DELAY = 2500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  btn_pulse,
   input  logic [15:0] sw,
   output logic [15:0] led,
   output logic [63:0] grid,
   output logic        check_ok,
   output logic [7:0]  score
);

   localparam int DLY_W = (DROP_DELAY > 1) ? $clog2(DROP_DELAY) : 1;

   state_t               state;
   cell_t                player;
   logic [7:0][7:0][1:0] board;
   logic [2:0]           cursor, target, drop_row, low_row, rd_row, rd_col;
   logic [5:0]           move_count;
   logic                 win, draw, invalid, winner_y, chk_start, chk_done, chk_win, col_full;
   logic [DLY_W-1:0]     dly_cnt;
   cell_t                rd_cell;

   logic left, right, sel;
   assign left  = btn_pulse[2];
   assign right = btn_pulse[3];
   assign sel   = btn_pulse[4];

`ifdef CONNECT_N_UNDO_EN
   logic       hist_valid;
   logic [2:0] hist_row, hist_col;
   logic       unused_in;
   assign unused_in = ^{btn_pulse[1], sw[15:1]};
`else
   logic unused_in;
   assign unused_in = ^{btn_pulse[1:0], sw[15:1]};
`endif

   assign col_full = board[3'(ROWS - 1)][cursor] != EMPTY;
   assign rd_cell  = cell_t'(board[rd_row][rd_col]);

   always_comb begin
      low_row = '0;
      for (int unsigned i = 0; i < ROWS; i++)
         if (board[ROWS - 1 - i][cursor] == EMPTY) low_row = 3'(ROWS - 1 - i);
   end

   connect_n_line_checker #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_checker (
      .clk(clk), .rst_n(rst_n), .start(chk_start), .row(target), .col(cursor),
      .player(player), .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
      .done(chk_done), .win(chk_win)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         board      <= '0;
         cursor     <= 3'(COLS / 2);
         player     <= RED;
         move_count <= '0;
         win        <= 1'b0;
         draw       <= 1'b0;
         invalid    <= 1'b0;
         winner_y   <= 1'b0;
         target     <= '0;
         drop_row   <= '0;
         dly_cnt    <= '0;
         chk_start  <= 1'b0;
`ifdef CONNECT_N_UNDO_EN
         hist_valid <= 1'b0;
         hist_row   <= '0;
         hist_col   <= '0;
`endif
      end else begin
         chk_start <= 1'b0;
         unique case (state)
            IDLE: if (sel) begin
               board      <= '0;
               move_count <= '0;
               win        <= 1'b0;
               draw       <= 1'b0;
               invalid    <= 1'b0;
               winner_y   <= 1'b0;
               player     <= sw[0] ? YELLOW : RED;
`ifdef CONNECT_N_UNDO_EN
               hist_valid <= 1'b0;
`endif
               state      <= PLAY;
            end
            PLAY:
`ifdef CONNECT_N_UNDO_EN
               if (btn_pulse[0] && hist_valid) begin
                  board[hist_row][hist_col] <= EMPTY;
                  move_count <= move_count - 6'd1;
                  player     <= other_player(player);
                  hist_valid <= 1'b0;
               end else
`endif
               if (sel) begin
                  if (col_full) invalid <= 1'b1;
                  else begin
                     target   <= low_row;
                     drop_row <= 3'(ROWS - 1);
                     dly_cnt  <= '0;
                     invalid  <= 1'b0;
                     state    <= DROP;
                  end
               end else if (left && !right && cursor != 3'd0) begin
                  cursor  <= cursor - 3'd1;
                  invalid <= 1'b0;
               end else if (right && !left && cursor != 3'(COLS - 1)) begin
                  cursor  <= cursor + 3'd1;
                  invalid <= 1'b0;
               end
            DROP:
               if (dly_cnt == DLY_W'(DROP_DELAY - 1)) begin
                  dly_cnt <= '0;
                  if (drop_row != target) drop_row <= drop_row - 3'd1;
                  else begin
                     board[target][cursor] <= player;
                     move_count <= move_count + 6'd1;
                     chk_start  <= 1'b1;
`ifdef CONNECT_N_UNDO_EN
                     hist_valid <= 1'b1;
                     hist_row   <= target;
                     hist_col   <= cursor;
`endif
                     state      <= CHECK;
                  end
               end else dly_cnt <= dly_cnt + 1'b1;
            CHECK:
               if (chk_done) begin
                  if (chk_win) begin
                     win      <= 1'b1;
                     winner_y <= (player == YELLOW);
                     state    <= GAME_OVER;
                  end else if (move_count == 6'(ROWS * COLS)) begin
                     draw  <= 1'b1;
                     state <= GAME_OVER;
                  end else begin
                     player <= other_player(player);
                     state  <= PLAY;
                  end
               end
            GAME_OVER: if (sel) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign led      = {state == GAME_OVER, winner_y, draw, move_count, cursor, invalid, win, player};
   assign check_ok = win;
   assign score    = {2'b00, move_count};

   // Board row r is shown upside down so row 0 (bottom) lands on grid row 7.
   always_comb begin
      grid = '0;
      for (int unsigned r = 0; r < ROWS; r++)
         for (int unsigned c = 0; c < COLS; c++)
            grid[(7 - r) * 8 + c] = board[r][c] != EMPTY;
      if (state == DROP) grid[{3'd7 - drop_row, cursor}] = 1'b1;
      if (state == PLAY) grid[{3'd0, cursor}] = 1'b1;
   end

endmodule

// File: tb/tb_connect_n_game.sv
// Directed bench for connect_n_game: a default-size board (fast drops) and a
// 2x2 board side by side, with hand-computed expected LED/grid/score values.
module tb_connect_n_game;
   import connect_n_pkg::*;

   localparam int L = 2, R = 3, S = 4, U = 0;

   logic        clk = 1'b0;
   logic        rst_n    [2];
   logic [4:0]  btn      [2];
   logic [15:0] sw       [2];
   logic [15:0] led      [2];
   logic [63:0] grid     [2];
   logic        check_ok [2];
   logic [7:0]  score    [2];
   int          cur      [2];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   connect_n_game #(.DROP_DELAY(2)) dut (
      .clk(clk), .rst_n(rst_n[0]), .btn_pulse(btn[0]), .sw(sw[0]),
      .led(led[0]), .grid(grid[0]), .check_ok(check_ok[0]), .score(score[0])
   );

   connect_n_game #(.COLS(2), .ROWS(2), .WIN_LEN(3), .DROP_DELAY(1)) dut_small (
      .clk(clk), .rst_n(rst_n[1]), .btn_pulse(btn[1]), .sw(sw[1]),
      .led(led[1]), .grid(grid[1]), .check_ok(check_ok[1]), .score(score[1])
   );

   function automatic logic [63:0] cellbit(input int r, input int c);
      return 64'h1 << ((7 - r) * 8 + c);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int d, input int c0);
      rst_n[d] = 1'b0;
      btn[d]   = '0;
      tick();
      rst_n[d] = 1'b1;
      cur[d]   = c0;
   endtask

   task automatic press(input int d, input int b);
      btn[d][b] = 1'b1;
      tick();
      btn[d][b] = 1'b0;
   endtask

   task automatic move_to(input int d, input int col);
      while (cur[d] > col) begin press(d, L); cur[d]--; end
      while (cur[d] < col) begin press(d, R); cur[d]++; end
   endtask

   task automatic wait_play(input int d);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (grid[d][7:0] != 8'h00 || led[d][15]) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("settle", 64'(ok), 64'd1);
   endtask

   task automatic drop(input int d, input int col);
      move_to(d, col);
      press(d, S);
      wait_play(d);
   endtask

   initial begin
      int seq3 [13] = '{0, 1, 1, 2, 6, 2, 2, 3, 5, 3, 6, 3, 3};
      logic [63:0] exp_grid;
      rst_n = '{1'b0, 1'b0};
      btn   = '{5'd0, 5'd0};
      sw    = '{16'd0, 16'd0};
      do_reset(1, 1);
      do_reset(0, 3);

      // Reset state and vertical red win in column 3
      check("reset_led", 64'(led[0]), 64'h0031);
      check("reset_grid", grid[0], 64'h0);
      check("reset_score", 64'(score[0]), 64'd0);
      check("reset_ok", 64'(check_ok[0]), 64'd0);
      press(0, S);
      check("start_grid", grid[0], 64'h08);
      press(0, S);
      check("anim_grid", grid[0], 64'h1 << 19);
      wait_play(0);
      check("move1_score", 64'(score[0]), 64'd1);
      check("move1_led", 64'(led[0]), 64'h00B2);
      for (int i = 0; i < 6; i++) drop(0, (i % 2 == 0) ? 4 : 3);
      check("vwin_ok", 64'(check_ok[0]), 64'd1);
      check("vwin_yellow", 64'(led[0][14]), 64'd0);
      check("vwin_score", 64'(score[0]), 64'd7);
      check("vwin_over", 64'(led[0][15]), 64'd1);
      check("vwin_led2", 64'(led[0][2]), 64'd1);
      exp_grid = cellbit(0, 3) | cellbit(1, 3) | cellbit(2, 3) | cellbit(3, 3) |
                 cellbit(0, 4) | cellbit(1, 4) | cellbit(2, 4);
      check("vwin_grid", grid[0], exp_grid);
      press(0, L);
      check("over_frozen_cur", 64'(led[0][6:4]), 64'd3);
      press(0, S);
      check("over_to_idle", 64'(led[0][15]), 64'd0);

      // Full column rejection and cursor rules
      do_reset(0, 3);
      press(0, S);
      for (int i = 0; i < 6; i++) drop(0, 0);
      check("full_score", 64'(score[0]), 64'd6);
      press(0, S);
      check("full_invalid", 64'(led[0][3]), 64'd1);
      check("full_count", 64'(score[0]), 64'd6);
      check("full_player", 64'(led[0][1:0]), 64'h1);
      check("full_in_play", 64'(grid[0][7:0]), 64'h01);
      press(0, L);
      check("sat_left", 64'(led[0][6:4]), 64'd0);
      btn[0][L] = 1'b1;
      btn[0][R] = 1'b1;
      tick();
      btn[0] = '0;
      check("both_no_move", 64'(led[0][6:4]), 64'd0);
      check("both_keeps_inv", 64'(led[0][3]), 64'd1);
      press(0, R);
      cur[0] = 1;
      check("move_clears_inv", 64'(led[0][3]), 64'd0);
      check("move_right", 64'(led[0][6:4]), 64'd1);
      move_to(0, 6);
      press(0, R);
      check("sat_right", 64'(led[0][6:4]), 64'd6);

      // Diagonal / win for red with yellow filler
      do_reset(0, 3);
      press(0, S);
      for (int i = 0; i < 13; i++) begin
         drop(0, seq3[i]);
         if (i == 11) begin
            check("diag_pre_ok", 64'(check_ok[0]), 64'd0);
            check("diag_pre_score", 64'(score[0]), 64'd12);
            check("diag_pre_over", 64'(led[0][15]), 64'd0);
         end
      end
      check("diag_ok", 64'(check_ok[0]), 64'd1);
      check("diag_yellow", 64'(led[0][14]), 64'd0);
      check("diag_score", 64'(score[0]), 64'd13);
      check("diag_over", 64'(led[0][15]), 64'd1);

      // 2x2 board, win length 3: draw after four pieces
      press(1, S);
      check("small_cursor", 64'(led[1][6:4]), 64'd1);
      drop(1, 1);
      drop(1, 1);
      press(1, S);
      check("small_invalid", 64'(led[1][3]), 64'd1);
      drop(1, 0);
      drop(1, 0);
      check("draw_flag", 64'(led[1][13]), 64'd1);
      check("draw_ok", 64'(check_ok[1]), 64'd0);
      check("draw_score", 64'(score[1]), 64'd4);
      check("draw_over", 64'(led[1][15]), 64'd1);
      check("draw_grid", grid[1], 64'h0303_0000_0000_0000);

      // Reset during a drop
      do_reset(0, 3);
      press(0, S);
      move_to(0, 5);
      press(0, S);
      tick();
      tick();
      check("mid_drop", 64'(grid[0][7:0]), 64'h00);
      rst_n[0] = 1'b0;
      tick();
      rst_n[0] = 1'b1;
      cur[0] = 3;
      check("rst_grid", grid[0], 64'h0);
      check("rst_led", 64'(led[0]), 64'h0031);
      check("rst_score", 64'(score[0]), 64'd0);
      repeat (20) tick();
      check("rst_stays_idle", grid[0], 64'h0);

      // Yellow start and undo button
      do_reset(0, 3);
      sw[0][0] = 1'b1;
      press(0, S);
      check("yellow_start", 64'(led[0][1:0]), 64'h2);
      drop(0, 2);
      check("undo_pre_cell", grid[0] & cellbit(0, 2), cellbit(0, 2));
      check("undo_pre_score", 64'(score[0]), 64'd1);
      check("undo_pre_player", 64'(led[0][1:0]), 64'h1);
      press(0, U);
`ifdef CONNECT_N_UNDO_EN
      check("undo_cell", grid[0] & cellbit(0, 2), 64'h0);
      check("undo_score", 64'(score[0]), 64'd0);
      check("undo_player", 64'(led[0][1:0]), 64'h2);
      press(0, U);
      check("undo2_score", 64'(score[0]), 64'd0);
      check("undo2_player", 64'(led[0][1:0]), 64'h2);
      check("undo2_grid", grid[0], 64'h04);
`else
      check("noundo_score", 64'(score[0]), 64'd1);
      check("noundo_player", 64'(led[0][1:0]), 64'h1);
      check("noundo_grid", grid[0], cellbit(0, 2) | 64'h04);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
